sync_debounce_vec: RTL and testbench
====================================

// Module: sync_debounce_vec
// PURPOSE
//  Parametrised multi-channel input conditioner for asynchronous switches/buttons.
//  Per channel: STAGES-deep synchroniser chain, then a debounce counter, then a
//  stable registered level plus optional one-cycle rise/fall pulses.
//  Sits between board I/O pins and control FSMs; replaces per-bit synchroniser
//  instances.
// PARAMETERS
//  WIDTH            4       number of independent channels
//  STAGES           2       synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  16      consecutive stable cycles needed to accept a new level (>=1)
//  RESET_VAL        '0      [WIDTH-1:0] reset value of sync chain and q
// PORTS
//  Clk    in   1      system clock; all state on posedge Clk
//  Reset  in   1      synchronous, active-high reset
//  d      in   WIDTH  raw asynchronous inputs
//  q      out  WIDTH  debounced, synchronised level
//  rise   out  WIDTH  1-cycle pulse when q[i] goes 0->1
//  fall   out  WIDTH  1-cycle pulse when q[i] goes 1->0
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (Clk, Reset).
//  - Reset: all sync stages and q = RESET_VAL; counters = 0; rise = fall = 0.
//    Reset overrides every other update in the same cycle.
//  - Sync chain: stage[0] <= d; stage[k] <= stage[k-1]; s = stage[STAGES-1].
//  - Counter width: CW = $clog2(DEBOUNCE_CYCLES+1). No wrap: the counter never
//    exceeds DEBOUNCE_CYCLES-1.
//  - Per-channel debounce, evaluated each cycle:
//      s==q                           : cnt <= 0
//      s!=q, cnt <  DEBOUNCE_CYCLES-1 : cnt <= cnt+1
//      s!=q, cnt == DEBOUNCE_CYCLES-1 : q <= s, cnt <= 0
//  - Latency: d change stable before edge N gives new q visible after edge
//    N+STAGES+DEBOUNCE_CYCLES-1. Example: STAGES=2, D=4 -> 6 edges incl. edge N.
//  - Glitch rejection:
//    - s differing from q for fewer than DEBOUNCE_CYCLES consecutive cycles
//      never changes q.
//    - Any return of s to q clears the counter; bounces restart the count.
//  - Pulses: rise[i]/fall[i] are registered and high for exactly the one cycle
//    in which the new q value is first visible. They are never both high.
//  - Channels are fully independent; simultaneous changes on several channels
//    update together.
//  - Reset mid-count discards the partial count and the sync contents. After
//    release, a held d != RESET_VAL is re-acquired with full latency and
//    produces a normal pulse.
//  - No pulse is generated by reset itself.
// CONFIGURATION
//  SYNC_DEBOUNCE_EDGE_EN defined: rise/fall registers and logic as above.
//  Not defined: rise and fall ports still exist, tied to '0; no edge flops
//  synthesised; q behaviour identical.
// TESTING  (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=4'h0, macro defined)
//  1. Reset=1 for 3 cycles with d=4'hF -> q=4'h0, rise=fall=0 during reset and
//     on the first cycle after release.
//  2. d[0] 0->1 before edge N, held -> q[0]=1 after edge N+5; rise[0]=1 that
//     cycle only; fall=0 throughout.
//  3. d[1] high for 3 cycles then low -> q[1] stays 0; rise[1] never asserts.
//  4. d[2] toggles every 2 cycles x5, then held 1 -> q[2] goes 1 exactly once,
//     6 edges after settling; exactly one rise[2].
//  5. d[3]=1; 1-cycle Reset 4 edges later -> q[3]=0. q[3]=1 six edges after
//     release. d=4'b1010 from q=0 -> q=4'b1010 and rise=4'b1010 in the same cycle.
//  6. Macro undefined, rerun tests 2-5 -> identical q timing; rise=fall=4'h0
//     every cycle.

Source files
------------

// File: rtl/sync_debounce_vec.sv
// sync_debounce_vec
//   Multi-channel conditioner for asynchronous switch/button inputs.
//   Each channel has a STAGES-deep synchroniser, then a debounce counter. The
//   counter must see DEBOUNCE_CYCLES consecutive cycles of a new synchronised
//   level before that level is accepted onto q.
//   Optional feature macro: SYNC_DEBOUNCE_EDGE_EN
//     defined   -> registered one-cycle rise/fall pulses on each q transition
//     undefined -> rise/fall ports tied low, no edge flops
//   All state is on posedge Clk. Reset is synchronous, active-high, and takes
//   priority over every other update.
module sync_debounce_vec #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      STAGES          = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // The counter only ever needs to reach DEBOUNCE_CYCLES-1. On that cycle
    // the new level is accepted and the counter goes back to zero.
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(32'(DEBOUNCE_CYCLES) - 32'd1);

    logic [WIDTH-1:0] sync_r    [STAGES];
    logic [WIDTH-1:0] s_s;
    logic [CW-1:0]    cnt_r     [WIDTH];
    logic [CW-1:0]    cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;

    assign s_s = sync_r[STAGES-1];
    assign q   = q_r;

    // Synchroniser chain: shift the raw inputs through STAGES flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce decision: per channel, work out the next counter value and the
    // next accepted level.
    always_comb begin
        q_nxt_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (s_s[i] == q_r[i]) begin
                // Synchronised input agrees with q, so any partial count
                // (a bounce) is discarded.
                cnt_nxt_s[i] = CNT_ZERO;
                q_nxt_s[i]   = q_r[i];
            end else if (cnt_r[i] == CNT_LAST) begin
                // Final stable cycle: accept the new level.
                cnt_nxt_s[i] = CNT_ZERO;
                q_nxt_s[i]   = s_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                q_nxt_s[i]   = q_r[i];
            end
        end
    end

    // Debounce state: counters and the accepted, registered level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_r <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            q_r <= q_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    // Edge pulses: high only in the cycle where a new q value first appears.
    // Reset itself never produces a pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            rise_r <= q_nxt_s & ~q_r;
            fall_r <= ~q_nxt_s & q_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`else
    assign rise = {WIDTH{1'b0}};
    assign fall = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sync_debounce_vec.sv
// Testbench for sync_debounce_vec with WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4,
// RESET_VAL=0. Expected rise/fall are forced to zero when the edge-pulse
// feature (SYNC_DEBOUNCE_EDGE_EN) is not compiled in.
module tb_sync_debounce_vec;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[$];

    always #5 Clk = ~Clk;

    sync_debounce_vec #(
        .WIDTH           (4),
        .STAGES          (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (4'h0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (d),
        .q     (q),
        .rise  (rise),
        .fall  (fall)
    );

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then compare the outputs 1 time unit later.
    task automatic apply(input string name, input int idx, input logic rst, input logic [3:0] dv,
                         input logic [3:0] qe, input logic [3:0] re, input logic [3:0] fe);
        Reset = rst;
        d     = dv;
        @(posedge Clk);
        #1;
        chk({name, "_q"},    idx, q,    qe);
        chk({name, "_rise"}, idx, rise, EDGE_EN ? re : 4'h0);
        chk({name, "_fall"}, idx, fall, EDGE_EN ? fe : 4'h0);
    endtask

    function automatic void add(input int n, input logic rst, input logic [3:0] dv,
                                input logic [3:0] qe, input logic [3:0] re, input logic [3:0] fe);
        vec_t v;
        v.rst  = rst;
        v.d    = dv;
        v.q    = qe;
        v.rise = re;
        v.fall = fe;
        for (int k = 0; k < n; k++) begin
            vecs.push_back(v);
        end
    endfunction

    initial begin
        int rise2_cnt;
        logic q2e;
        logic r2e;

        Reset = 1'b1;
        d     = 4'hF;

        // Test 1: reset held with inputs high, then release.
        add(3, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);   // first cycle after release
        add(4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);   // single-cycle F after release is rejected
        // Test 2: d[0] rises and is held; q[0] appears 6 edges later, with one rise pulse.
        add(5, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h0);
        add(1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
        // Test 3: d[1] is high for only 3 cycles, so q[1] must not change.
        add(3, 1'b0, 4'h3, 4'h1, 4'h0, 4'h0);
        add(5, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply("tbl", i, vecs[i].rst, vecs[i].d, vecs[i].q, vecs[i].rise, vecs[i].fall);
        end

        // Test 4: d[2] bounces with 2-cycle highs, then is held high from step 12.
        rise2_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            logic d2;
            d2  = (j < 12) ? ((j % 4) < 2) : 1'b1;
            q2e = (j >= 17);
            r2e = (j == 17);
            apply("bounce", j, 1'b0, {1'b0, d2, 1'b0, 1'b1},
                  {1'b0, q2e, 1'b0, 1'b1}, {1'b0, r2e, 2'b00}, 4'h0);
            if (rise[2] === 1'b1) rise2_cnt++;
        end
        chk("bounce_rise_count", 0, 4'(rise2_cnt), EDGE_EN ? 4'd1 : 4'd0);

        // Test 5: reset in the middle of acquiring d[3]; everything is re-acquired after release.
        for (int j = 0; j < 4; j++) begin
            apply("pre_rst", j, 1'b0, 4'b1101, 4'b0101, 4'h0, 4'h0);
        end
        apply("mid_rst", 0, 1'b1, 4'b1101, 4'h0, 4'h0, 4'h0);   // no fall pulse from reset
        for (int j = 0; j < 5; j++) begin
            apply("reacq", j, 1'b0, 4'b1101, 4'h0, 4'h0, 4'h0);
        end
        apply("reacq_edge", 0, 1'b0, 4'b1101, 4'b1101, 4'b1101, 4'h0);
        apply("reacq_hold", 0, 1'b0, 4'b1101, 4'b1101, 4'h0, 4'h0);

        // All channels fall together.
        for (int j = 0; j < 5; j++) begin
            apply("fall_wait", j, 1'b0, 4'h0, 4'b1101, 4'h0, 4'h0);
        end
        apply("fall_edge", 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'b1101);
        apply("fall_hold", 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Simultaneous rise on two channels.
        for (int j = 0; j < 5; j++) begin
            apply("multi_wait", j, 1'b0, 4'b1010, 4'h0, 4'h0, 4'h0);
        end
        apply("multi_edge", 0, 1'b0, 4'b1010, 4'b1010, 4'b1010, 4'h0);
        apply("multi_hold", 0, 1'b0, 4'b1010, 4'b1010, 4'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
